multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle controller
// Holds the FSM state enum, opcode constants, alu_control codes, ALU operation
// classes and datapath mux select codes. HALT state exists only when
// MULTICYCLE_CONTROLLER_HALT_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps ALU operation class and funct fields to alu_control
// Ports: alu_op (class: add/sub/funct), funct3, funct7b5, op5 (opcode bit 5,
// set for R-type) -> alu_control.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // funct7b5 only selects sub for register-register ops;
                    // for immediates bit 30 belongs to the immediate.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with memory wait timeout
// Inputs: clk, reset (sync, active-high), op, funct3, funct7b5, zero, mem_ready.
// Outputs: mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
// alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal_op, mem_timeout.
// MULTICYCLE_CONTROLLER_HALT_EN adds halt_req/halted and a HALT state entered
// in place of FETCH while halt_req is high.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
    input  logic       halt_req,
    output logic       halted,
`endif
    output logic       mem_req,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic       mem_timeout
);

    // Timeout fires on the TIMEOUT_CYCLES-th consecutive wait cycle, i.e.
    // while the counter still holds the count of the preceding wait cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic [1:0] alu_op;
    logic [2:0] alu_dec;

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_dec)
    );

    assign alu_control = reset ? ALU_ADD : alu_dec;

    always_comb begin
        case (op)
            OP_LW, OP_ITYPE: imm_src = IMM_I;
            OP_SW:           imm_src = IMM_S;
            OP_BEQ:          imm_src = IMM_B;
            OP_JAL:          imm_src = IMM_J;
            default:         imm_src = IMM_I;
        endcase
    end

    always_comb begin
        state_next  = state;
        alu_op      = ALUOP_ADD;
        mem_req     = 1'b0;
        pc_write    = 1'b0;
        adr_src     = ADR_PC;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        halted      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ITYPE:     state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = ADR_ALUOUT;
                result_src = RES_ALUOUT;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = ADR_ALUOUT;
                mem_write = mem_ready;
                if (mem_ready) state_next = S_FETCH;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) state_next = S_FETCH;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        // Abort only when still waiting; a ready on the threshold cycle has
        // already completed the transaction above. Strobes are 0 here because
        // they all depend on mem_ready.
        if (mem_req && !mem_ready && (wait_cnt == TIMEOUT_LAST)) begin
            mem_timeout = 1'b1;
            state_next  = S_FETCH;
        end

`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        if ((state_next == S_FETCH) && halt_req) state_next = S_HALT;
`endif

        if (reset) begin
            alu_op      = ALUOP_ADD;
            mem_req     = 1'b0;
            pc_write    = 1'b0;
            adr_src     = ADR_PC;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            result_src  = RES_ALUOUT;
            alu_src_a   = SRCA_PC;
            alu_src_b   = SRCB_RS2;
            reg_write   = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
            halted      = 1'b0;
`endif
        end
    end

    // Counter is zero on entry to every request state: it clears on any cycle
    // that is not a continuing wait (completion, timeout or non-request state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (mem_req && !mem_ready && !mem_timeout) wait_cnt <= wait_cnt + 8'd1;
            else                                       wait_cnt <= 8'd0;
        end
    end

endmodule
